logevt_wr: RTL and testbench

Hardware event writer that sits directly upstream of the log buffer and shares that buffer's slave bus with the CPU. It queues fixed-size event records raised by hardware monitors (watchdog, stack monitor, reset cause) and writes each one into the next log entry atomically. The read/write-index sequence it uses is the same one the software driver uses. CPU accesses pass through unchanged while the writer is idle.

---
 rtl/logevt_wr.sv | 176 +++++++++++++++++
 tb/tb_logevt_wr.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logevt_wr.sv
// logevt_wr: queues fixed-size hardware event records and writes each one into
// the next log buffer entry, sharing the buffer's slave bus with the CPU.
module logevt_wr #(
  parameter int NUM_ENTRIES = 32,
  parameter int EVQ_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        evt_stb,
  input  logic [63:0] evt_data,
  output logic        evt_ready,
  output logic [7:0]  drop_cnt,
  output logic        busy,
  input  logic        cpu_stb,
  input  logic        cpu_we,
  input  logic        cpu_addr,
  input  logic [15:0] cpu_data_in,
  output logic [31:0] cpu_data_out,
  output logic        cpu_ack,
  output logic        lb_stb,
  output logic        lb_we,
  output logic        lb_addr,
  output logic [15:0] lb_data_out,
  input  logic [31:0] lb_data_in,
  input  logic        lb_ack
);

  localparam int         AW      = (EVQ_DEPTH > 1) ? $clog2(EVQ_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(EVQ_DEPTH);
  localparam logic [7:0] IX_MASK = 8'(NUM_ENTRIES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_IX  = 3'd1;
  localparam logic [2:0] S_WR_IX  = 3'd2;
  localparam logic [2:0] S_WR_B   = 3'd3;
  localparam logic [2:0] S_WR_FIN = 3'd4;

  logic [63:0]   fifo_q [EVQ_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic [2:0]    state_q, state_d;
  logic [7:0]    p_q, p_d, g_q, g_d;
  logic [2:0]    k_q, k_d;
  logic [7:0]    drop_q;

  logic          fifo_full_s, push_s, pop_s, drop_s;
  logic [63:0]   head_s;
  logic [7:0]    head_byte_s, np_s, ng_s;

  assign fifo_full_s = (cnt_q == DEPTH_C);
  assign pop_s       = (state_q == S_WR_FIN);
  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
  assign push_s      = evt_stb && (!fifo_full_s || pop_s);
  assign drop_s      = evt_stb && fifo_full_s && !pop_s;
  assign head_s      = fifo_q[rp_q];
  assign head_byte_s = head_s[{k_q, 3'b000} +: 8];
  assign np_s        = (p_q + 8'd1) & IX_MASK;
  assign ng_s        = (np_s == g_q) ? ((g_q + 8'd1) & IX_MASK) : g_q;

  assign evt_ready = !fifo_full_s;
  assign drop_cnt  = drop_q;
  assign busy      = (state_q != S_IDLE);

  // Bus mux and next-state logic for the writer sequence
  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    g_d          = g_q;
    k_d          = k_q;
    lb_stb       = 1'b0;
    lb_we        = 1'b0;
    lb_addr      = 1'b0;
    lb_data_out  = 16'h0000;
    cpu_ack      = 1'b0;
    cpu_data_out = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        lb_stb       = cpu_stb;
        lb_we        = cpu_stb & cpu_we;
        lb_addr      = cpu_stb & cpu_addr;
        lb_data_out  = cpu_stb ? cpu_data_in : 16'h0000;
        cpu_ack      = lb_ack;
        cpu_data_out = cpu_stb ? lb_data_in : 32'h0000_0000;
        if ((cnt_q != '0) && !cpu_stb) begin
          state_d = S_RD_IX;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_IX: begin
        lb_stb  = 1'b1;
        lb_addr = 1'b1;
        p_d     = lb_data_in[15:8] & IX_MASK;
        g_d     = lb_data_in[7:0] & IX_MASK;
        state_d = S_WR_IX;
      end
      S_WR_IX: begin
        lb_stb      = 1'b1;
        lb_we       = 1'b1;
        lb_addr     = 1'b1;
        lb_data_out = {p_q, g_q};
        state_d     = S_WR_B;
      end
      S_WR_B: begin
        lb_stb      = 1'b1;
        lb_we       = 1'b1;
        lb_data_out = {8'h00, head_byte_s};
        if (k_q == 3'd7) begin
          k_d     = 3'd0;
          state_d = S_WR_FIN;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = S_WR_B;
        end
      end
      S_WR_FIN: begin
        lb_stb      = 1'b1;
        lb_we       = 1'b1;
        lb_addr     = 1'b1;
        lb_data_out = {np_s, ng_s};
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Writer state, latched indices and byte counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= 8'd0;
      g_q     <= 8'd0;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      g_q     <= g_d;
      k_q     <= k_d;
    end
  end

  // Event storage; contents are meaningless outside the occupied window
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wp_q] <= evt_data;
    end
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      drop_q <= 8'd0;
    end else begin
      if (push_s) begin
        wp_q <= wp_q + 1'b1;
      end
      if (pop_s) begin
        rp_q <= rp_q + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop_s && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_logevt_wr.sv
// Bench for logevt_wr: a behavioural log buffer on the slave side, directed
// scenarios with random event payloads, checked against spec-level expectations.
module tb_logevt_wr;

  localparam int NE = 32;
  localparam int QD = 4;
  localparam int IW = $clog2(NE);

  logic        clk = 1'b0;
  logic        rst;
  logic        evt_stb;
  logic [63:0] evt_data;
  logic        evt_ready;
  logic [7:0]  drop_cnt;
  logic        busy;
  logic        cpu_stb, cpu_we, cpu_addr;
  logic [15:0] cpu_data_in;
  logic [31:0] cpu_data_out;
  logic        cpu_ack;
  logic        lb_stb, lb_we, lb_addr;
  logic [15:0] lb_data_out;
  logic [31:0] lb_data_in;
  logic        lb_ack;

  int checks   = 0;
  int failures = 0;

  logevt_wr #(.NUM_ENTRIES(NE), .EVQ_DEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .evt_stb(evt_stb), .evt_data(evt_data), .evt_ready(evt_ready),
    .drop_cnt(drop_cnt), .busy(busy),
    .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack),
    .lb_stb(lb_stb), .lb_we(lb_we), .lb_addr(lb_addr),
    .lb_data_out(lb_data_out), .lb_data_in(lb_data_in), .lb_ack(lb_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int e, input int b);
    return 8'(e * 7 + b) ^ 8'hA5;
  endfunction

  // Behavioural log buffer: entries of 64 bytes, put/get indices, byte pointers
  logic [7:0] lb_mem [NE][64];
  logic [7:0] lb_put, lb_get, lb_wptr, lb_rptr;
  logic       lb_init_q = 1'b0;

  always @(posedge clk) begin
    if (!lb_init_q) begin
      for (int e = 0; e < NE; e++)
        for (int b = 0; b < 64; b++) lb_mem[e][b] <= pat(e, b);
      lb_put <= 8'd0; lb_get <= 8'd0; lb_wptr <= 8'd0; lb_rptr <= 8'd0;
      lb_init_q <= 1'b1;
    end else if (lb_stb) begin
      if (lb_we && lb_addr) begin
        lb_put <= lb_data_out[15:8]; lb_get <= lb_data_out[7:0];
        lb_wptr <= 8'd0; lb_rptr <= 8'd0;
      end else if (lb_we) begin
        lb_mem[lb_put[IW-1:0]][lb_wptr[5:0]] <= lb_data_out[7:0];
        lb_wptr <= lb_wptr + 8'd1;
      end else if (lb_addr) begin
        lb_wptr <= 8'd0; lb_rptr <= 8'd0;
      end else begin
        lb_rptr <= lb_rptr + 8'd1;
      end
    end
  end

  assign lb_data_in = lb_addr ? {lb_wptr, lb_rptr, lb_put, lb_get}
                              : {24'h0, lb_mem[lb_get[IW-1:0]][lb_rptr[5:0]]};
  assign lb_ack = lb_stb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ix(input int p, input int g);
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_addr = 1'b1;
    cpu_data_in = {8'(p), 8'(g)};
    #1;
    check("cpu_wr_ack", cpu_ack, 1);
    tick();
    cpu_stb = 1'b0; cpu_we = 1'b0; cpu_addr = 1'b0; cpu_data_in = 16'h0;
  endtask

  task automatic push_evt(input logic [63:0] d);
    evt_stb = 1'b1; evt_data = d;
    tick();
    evt_stb = 1'b0;
  endtask

  task automatic check_entry(input string tag, input int e, input logic [63:0] d);
    for (int b = 0; b < 8; b++) check({tag, "_byte"}, lb_mem[e][b], d[8*b +: 8]);
    check({tag, "_byte8_untouched"}, lb_mem[e][8], pat(e, 8));
    check({tag, "_byte63_untouched"}, lb_mem[e][63], pat(e, 63));
  endtask

  // Index rule: put advances by one; get advances only when the log would overflow
  task automatic check_ix(input string tag, input int p, input int g);
    int np, ng;
    np = (p + 1) % NE;
    ng = (np == g) ? (g + 1) % NE : g;
    check({tag, "_put"}, lb_put, np);
    check({tag, "_get"}, lb_get, ng);
  endtask

  logic [63:0] d;
  logic [63:0] ov_d [6];
  logic [63:0] sat_d [4];
  int n, first, seen, stall, got, bad, p, g;

  initial begin
    rst = 1'b1; evt_stb = 1'b0; evt_data = 64'h0;
    cpu_stb = 1'b0; cpu_we = 1'b0; cpu_addr = 1'b0; cpu_data_in = 16'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_evt_ready", evt_ready, 1);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_lb_stb", lb_stb, 0);
    check("rst_cpu_data_out", cpu_data_out, 0);
    check("rst_cpu_ack", cpu_ack, 0);

    // Single event, put=5 get=2
    set_ix(5, 2);
    cpu_stb = 1'b1; cpu_addr = 1'b1; #1;
    check("pass_rd_data", cpu_data_out, {8'd0, 8'd0, 8'd5, 8'd2});
    check("pass_rd_ack", cpu_ack, 1);
    tick(); cpu_stb = 1'b0; cpu_addr = 1'b0;
    push_evt(64'h0807060504030201);
    check("single_idle_after_push", busy, 0);
    n = 0; seen = 0; first = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) begin
        n++;
        if (seen == 0) first = i;
        seen = 1;
      end else if (seen != 0) begin
        break;
      end
    end
    check("single_start_latency", first, 0);
    check("single_busy_cycles", n, 11);
    check_entry("single_entry5", 5, 64'h0807060504030201);
    check_ix("single_ix", 5, 2);

    // Wrap/overwrite at the top of the index range
    set_ix(31, 0);
    d = {$urandom, $urandom};
    push_evt(d);
    repeat (14) tick();
    check("wrap_done", busy, 0);
    check_entry("wrap_entry31", 31, d);
    check("wrap_put", lb_put, 0);
    check("wrap_get", lb_get, 1);

    // Random indices and payloads; first iteration forces the overwrite case
    for (int it = 0; it < 4; it++) begin
      p = $urandom_range(0, NE - 1);
      g = (it == 0) ? (p + 1) % NE : $urandom_range(0, NE - 1);
      set_ix(p, g);
      d = {$urandom, $urandom};
      push_evt(d);
      repeat (14) tick();
      check("rand_done", busy, 0);
      check_entry("rand_entry", p, d);
      check_ix("rand_ix", p, g);
    end

    // FIFO overflow: six back-to-back requests into an empty FIFO
    set_ix(10, 3);
    for (int i = 0; i < 6; i++) begin
      ov_d[i] = {$urandom, $urandom};
      evt_stb = 1'b1; evt_data = ov_d[i];
      tick();
      check("ovf_evt_ready", evt_ready, (i < 3) ? 1 : 0);
    end
    evt_stb = 1'b0;
    check("ovf_drop_cnt", drop_cnt, 2);
    repeat (60) tick();
    check("ovf_drained_busy", busy, 0);
    check("ovf_drained_ready", evt_ready, 1);
    for (int i = 0; i < 4; i++) check_entry("ovf_entry", 10 + i, ov_d[i]);
    check("ovf_put", lb_put, 14);
    check("ovf_get", lb_get, 3);

    // CPU contention at the start cycle and during WR_B
    set_ix(7, 20);
    d = {$urandom, $urandom};
    push_evt(d);
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 1'b1; #1;
    check("cont_start_ack", cpu_ack, 1);
    check("cont_start_data", cpu_data_out, {8'd0, 8'd0, 8'd7, 8'd20});
    check("cont_start_idle", busy, 0);
    tick();
    check("cont_held_idle", busy, 0);
    cpu_stb = 1'b0; cpu_addr = 1'b0;
    tick();
    check("cont_start_next", busy, 1);
    repeat (4) tick();
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 1'b1; #1;
    stall = 0; got = 0; bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (cpu_ack) begin
        got = 1;
        break;
      end
      stall++;
      if (busy !== 1'b1 || cpu_data_out !== 32'h0) bad++;
      tick();
    end
    check("cont_got_ack", got, 1);
    check("cont_stall_cycles", stall, 7);
    check("cont_stall_gated", bad, 0);
    check("cont_ack_idle", busy, 0);
    check("cont_ack_data", cpu_data_out, {8'd0, 8'd0, 8'd8, 8'd20});
    tick();
    cpu_stb = 1'b0; cpu_addr = 1'b0;
    check_entry("cont_entry7", 7, d);

    // Reset during WR_B k=3 with further events queued
    set_ix(12, 1);
    d = {$urandom, $urandom};
    evt_data = d; evt_stb = 1'b1;
    tick();
    evt_data = {$urandom, $urandom};
    repeat (2) tick();
    evt_stb = 1'b0;
    repeat (4) tick();
    check("rstmid_busy", busy, 1);
    check("rstmid_byte3_on_bus", lb_data_out, {8'h00, d[31:24]});
    rst = 1'b1; #1;
    check("rstmid_busy_async", busy, 0);
    check("rstmid_lb_stb_async", lb_stb, 0);
    check("rstmid_evt_ready", evt_ready, 1);
    check("rstmid_drop_cnt", drop_cnt, 0);
    check("rstmid_cpu_ack", cpu_ack, 0);
    repeat (2) tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (lb_stb) n++;
    end
    check("rstmid_no_lb_stb", n, 0);
    check("rstmid_put", lb_put, 12);
    check("rstmid_get", lb_get, 1);
    for (int b = 0; b < 3; b++) check("rstmid_partial_byte", lb_mem[12][b], d[8*b +: 8]);

    // drop_cnt saturation with the writer held off by a CPU strobe
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 1'b1;
    for (int i = 0; i < 304; i++) begin
      evt_data = {$urandom, $urandom};
      if (i < 4) sat_d[i] = evt_data;
      evt_stb = 1'b1;
      tick();
      if (i == 103) check("sat_drop_100", drop_cnt, 100);
    end
    evt_stb = 1'b0;
    check("sat_drop_255", drop_cnt, 255);
    check("sat_ready_low", evt_ready, 0);
    check("sat_writer_held", busy, 0);
    cpu_stb = 1'b0; cpu_addr = 1'b0;
    repeat (60) tick();
    check("sat_drained_busy", busy, 0);
    check("sat_drained_ready", evt_ready, 1);
    check("sat_drop_held", drop_cnt, 255);
    for (int i = 0; i < 4; i++) check_entry("sat_entry", 12 + i, sat_d[i]);
    check("sat_put", lb_put, 16);
    check("sat_get", lb_get, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
